// File: rtl/ahb_pkg.sv
// Shared AHB encodings, arbiter state type and small index helpers.
// Latency: none; declarations and pure functions only.
// Backpressure: not applicable.
package ahb_pkg;

    localparam int NUM_MASTERS = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    // LOCK_LAST is the single trailing transfer after the owner releases HLOCK.
    typedef enum logic [1:0] {
        ST_ARB       = 2'd0,
        ST_BURST     = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_LOCK_LAST = 2'd3
    } arb_state_t;

    // Beat count of a burst; undefined-length INCR counts as one because it never freezes the grant.
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
            default:                      burst_len = 5'd1;
        endcase
    endfunction

    function automatic logic [NUM_MASTERS-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

    function automatic logic [1:0] index4(input logic [NUM_MASTERS-1:0] oh);
        case (oh)
            4'b0010: index4 = 2'd1;
            4'b0100: index4 = 2'd2;
            4'b1000: index4 = 2'd3;
            default: index4 = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arbiter_rr_pick4.sv
// Next-owner selector: fixed priority or round-robin over four requesters.
// Latency: purely combinational.
// Backpressure: none; parks on DEFAULT_MASTER when nobody requests.
module rr_pick4
    import ahb_pkg::*;
#(
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [1:0]             ptr,
    input  logic                   mode,
    output logic [NUM_MASTERS-1:0] pick
);

    logic       found;
    logic [1:0] idx;

    // Scan ptr+1..ptr+4 in round-robin mode, 0..3 in fixed mode; first requester wins.
    always_comb begin
        pick  = onehot4(2'(DEFAULT_MASTER));
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = mode ? (ptr + 2'(k + 1)) : 2'(k);
            if (!found && req[idx]) begin
                pick  = onehot4(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// 4-master AHB arbiter: one-hot registered grants plus HMASTER/HMASTLOCK for the address phase.
// Latency: request sampled at a ready edge moves the grant after that same edge; HMASTER trails by one ready cycle.
// Backpressure: HREADY low freezes grants, HMASTER, HMASTLOCK, beat counter and FSM.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned ARB_MODE       = 1
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HBUSREQx0,
    input  logic       HBUSREQx1,
    input  logic       HBUSREQx2,
    input  logic       HBUSREQx3,
    input  logic       HLOCKx0,
    input  logic       HLOCKx1,
    input  logic       HLOCKx2,
    input  logic       HLOCKx3,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       HREADY,
    output logic       HGRANTx0,
    output logic       HGRANTx1,
    output logic       HGRANTx2,
    output logic       HGRANTx3,
    output logic [1:0] HMASTER,
    output logic       HMASTLOCK
);

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] lock;
    logic [NUM_MASTERS-1:0] pick;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] grant_d;
    logic [NUM_MASTERS-1:0] arb_grant;
    logic [1:0]             owner;
    logic [1:0]             ptr_q;
    logic [1:0]             ptr_d;
    logic [4:0]             cnt_q;
    logic [4:0]             cnt_d;
    logic [1:0]             hmaster_q;
    logic                   hmastlock_q;
    logic                   owner_lock;
    logic                   fixed_burst;
    arb_state_t             state_q;
    arb_state_t             state_d;
    arb_state_t             arb_state;

    assign req         = {HBUSREQx3, HBUSREQx2, HBUSREQx1, HBUSREQx0};
    assign lock        = {HLOCKx3, HLOCKx2, HLOCKx1, HLOCKx0};
    assign owner       = index4(grant_q);
    assign owner_lock  = lock[owner];
    assign fixed_burst = burst_len(HBURST) > 5'd1;

    rr_pick4 #(
        .DEFAULT_MASTER(DEFAULT_MASTER)
    ) u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .mode (ARB_MODE != 0),
        .pick (pick)
    );

    // Decision an unconstrained bus would take: lock and fixed bursts pin the owner, else re-arbitrate.
    always_comb begin
        arb_state = ST_ARB;
        arb_grant = pick;
        if (owner_lock) begin
            arb_state = ST_LOCKED;
            arb_grant = grant_q;
        end else if (HTRANS == HTRANS_NONSEQ && fixed_burst) begin
            arb_state = ST_BURST;
            arb_grant = grant_q;
        end
    end

    // Next state, grant and beat counter; nothing moves without HREADY.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        if (HREADY) begin
            case (HTRANS)
                HTRANS_NONSEQ: cnt_d = burst_len(HBURST) - 5'd1;
                HTRANS_SEQ:    cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
                default:       cnt_d = cnt_q;
            endcase
            case (state_q)
                ST_ARB: begin
                    state_d = arb_state;
                    grant_d = arb_grant;
                end
                ST_BURST: begin
                    case (HTRANS)
                        HTRANS_SEQ: begin
                            // Last beat's address is going out: hand over now.
                            if (cnt_q <= 5'd1) begin
                                grant_d = pick;
                                state_d = ST_ARB;
                            end
                        end
                        HTRANS_BUSY: begin
                        end
                        default: begin
                            // IDLE or a fresh NONSEQ ends the burst early.
                            if (HTRANS == HTRANS_IDLE) cnt_d = 5'd0;
                            state_d = arb_state;
                            grant_d = arb_grant;
                        end
                    endcase
                end
                ST_LOCKED: begin
                    if (!owner_lock) state_d = ST_LOCK_LAST;
                end
                ST_LOCK_LAST: begin
                    grant_d = pick;
                    state_d = ST_ARB;
                end
                default: state_d = ST_ARB;
            endcase
        end
    end

    assign ptr_d = (grant_d != grant_q) ? index4(grant_d) : ptr_q;

    // Grant, pointer, counter, FSM and address-phase owner registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q     <= onehot4(2'(DEFAULT_MASTER));
            ptr_q       <= 2'(DEFAULT_MASTER);
            cnt_q       <= 5'd0;
            state_q     <= ST_ARB;
            hmaster_q   <= 2'(DEFAULT_MASTER);
            hmastlock_q <= 1'b0;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            if (HREADY) begin
                hmaster_q   <= owner;
                hmastlock_q <= owner_lock;
            end
        end
    end

    assign HGRANTx0  = grant_q[0];
    assign HGRANTx1  = grant_q[1];
    assign HGRANTx2  = grant_q[2];
    assign HGRANTx3  = grant_q[3];
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: fixed-priority and round-robin instances share one stimulus stream.
// Latency: a reference model advances on every rising edge and is compared on every falling edge.
// Backpressure: HREADY is driven low in directed stalls and at random.
module tb_ahb_arbiter;
    import ahb_pkg::*;

    logic       HCLK;
    logic       HRESETn;
    logic [3:0] busreq;
    logic [3:0] lock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;

    logic [3:0] g_fp, g_rr;
    logic [1:0] hm_fp, hm_rr;
    logic       ml_fp, ml_rr;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Reference model, index 0 = fixed priority, 1 = round robin.
    int m_owner[2];
    int m_ptr[2];
    int m_left[2];
    int m_hmaster[2];
    bit m_hmastlock[2];
    bit m_lockmode[2];
    bit m_tail[2];

    ahb_arbiter #(.DEFAULT_MASTER(0), .ARB_MODE(0)) dut_fp (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HBUSREQx0(busreq[0]), .HBUSREQx1(busreq[1]), .HBUSREQx2(busreq[2]), .HBUSREQx3(busreq[3]),
        .HLOCKx0(lock[0]), .HLOCKx1(lock[1]), .HLOCKx2(lock[2]), .HLOCKx3(lock[3]),
        .HTRANS(htrans), .HBURST(hburst), .HREADY(hready),
        .HGRANTx0(g_fp[0]), .HGRANTx1(g_fp[1]), .HGRANTx2(g_fp[2]), .HGRANTx3(g_fp[3]),
        .HMASTER(hm_fp), .HMASTLOCK(ml_fp)
    );

    ahb_arbiter #(.DEFAULT_MASTER(0), .ARB_MODE(1)) dut_rr (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HBUSREQx0(busreq[0]), .HBUSREQx1(busreq[1]), .HBUSREQx2(busreq[2]), .HBUSREQx3(busreq[3]),
        .HLOCKx0(lock[0]), .HLOCKx1(lock[1]), .HLOCKx2(lock[2]), .HLOCKx3(lock[3]),
        .HTRANS(htrans), .HBURST(hburst), .HREADY(hready),
        .HGRANTx0(g_rr[0]), .HGRANTx1(g_rr[1]), .HGRANTx2(g_rr[2]), .HGRANTx3(g_rr[3]),
        .HMASTER(hm_rr), .HMASTLOCK(ml_rr)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'b0000;
        v[i[1:0]] = 1'b1;
        return v;
    endfunction

    function automatic int beats(input logic [2:0] b);
        if (b == 3'd2 || b == 3'd3) return 4;
        if (b == 3'd4 || b == 3'd5) return 8;
        if (b == 3'd6 || b == 3'd7) return 16;
        return 1;
    endfunction

    function automatic int pick_m(input int mode, input int ptr, input logic [3:0] r);
        int idx;
        if (mode == 0) begin
            for (int i = 0; i < 4; i++) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                idx = (ptr + k) % 4;
                if (r[idx]) return idx;
            end
        end
        return 0;
    endfunction

    task automatic cmp(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {grant,hmaster,lock}=%b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = 0; m_ptr[m] = 0; m_left[m] = 0; m_hmaster[m] = 0;
            m_hmastlock[m] = 0; m_lockmode[m] = 0; m_tail[m] = 0;
        end
    endtask

    task automatic handover(input int m);
        int n;
        n = pick_m(m, m_ptr[m], busreq);
        if (n != m_owner[m]) m_ptr[m] = n;
        m_owner[m] = n;
    endtask

    // One ready-qualified bus cycle as seen by the arbitration rules.
    task automatic model_step();
        int o;
        bit lk;
        if (!hready) return;
        for (int m = 0; m < 2; m++) begin
            o  = m_owner[m];
            lk = lock[o];
            m_hmaster[m]   = o;
            m_hmastlock[m] = lk;
            if (m_lockmode[m]) begin
                if (!lk) begin
                    m_lockmode[m] = 0;
                    m_tail[m] = 1;
                end
            end else if (m_tail[m]) begin
                m_tail[m] = 0;
                handover(m);
            end else if (m_left[m] > 0 && htrans == HTRANS_SEQ) begin
                m_left[m]--;
                if (m_left[m] == 0) handover(m);
            end else if (m_left[m] > 0 && htrans == HTRANS_BUSY) begin
            end else begin
                m_left[m] = 0;
                if (lk) m_lockmode[m] = 1;
                else if (htrans == HTRANS_NONSEQ && beats(hburst) > 1) m_left[m] = beats(hburst) - 1;
                else handover(m);
            end
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [1:0] t,
                         input logic [2:0] b, input logic rdy);
        busreq = r; lock = l; htrans = t; hburst = b; hready = rdy;
    endtask

    task automatic cyc();
        @(posedge HCLK);
        if (HRESETn) model_step();
        else model_reset();
        #1;
    endtask

    // Every falling edge: both instances against the model.
    initial begin
        forever begin
            @(negedge HCLK);
            if (chk_en) begin
                cmp("model_fp", {g_fp, hm_fp, ml_fp}, {oh(m_owner[0]), 2'(m_hmaster[0]), m_hmastlock[0]});
                cmp("model_rr", {g_rr, hm_rr, ml_rr}, {oh(m_owner[1]), 2'(m_hmaster[1]), m_hmastlock[1]});
            end
        end
    end

    initial begin
        HRESETn = 1'b1;
        drive(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        model_reset();
        #1 HRESETn = 1'b0;
        #1 chk_en = 1;
        cyc(); cyc();
        HRESETn = 1'b1;

        // Idle bus parks on master 0.
        for (int k = 0; k < 10; k++) begin
            cyc();
            cmp("idle_park", {g_rr, hm_rr, ml_rr}, 7'b0001_00_0);
        end

        // Round robin rotation with everybody requesting.
        drive(4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            cmp("rr_rotate", {g_rr, hm_rr, ml_rr}, {oh(k % 4), 2'((k - 1) % 4), 1'b0});
        end

        // Fixed priority picks.
        drive(4'b1010, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1); cyc();
        cmp("fp_1010", {g_fp, hm_fp, ml_fp}, 7'b0010_00_0);
        drive(4'b1000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1); cyc();
        cmp("fp_1000", {g_fp, hm_fp, ml_fp}, 7'b1000_01_0);
        drive(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1); cyc();
        cmp("fp_none", {g_fp, hm_fp, ml_fp}, 7'b0001_11_0);

        // INCR4 by master 2 with master 0 waiting, then the same with a 2-cycle stall.
        for (int pass = 0; pass < 2; pass++) begin
            drive(4'b0100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1); cyc();
            cmp("b4_grant2", {g_rr, hm_rr, ml_rr}, 7'b0100_00_0);
            drive(4'b0101, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4, 1'b1); cyc();
            cmp("b4_beat1", {g_rr, hm_rr, ml_rr}, 7'b0100_10_0);
            drive(4'b0101, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b1); cyc();
            cmp("b4_beat2", {g_rr, hm_rr, ml_rr}, 7'b0100_10_0);
            if (pass == 1) begin
                hready = 1'b0;
                cyc(); cyc();
                cmp("b4_stall", {g_rr, hm_rr, ml_rr}, 7'b0100_10_0);
                hready = 1'b1;
            end
            cyc();
            cmp("b4_beat3", {g_rr, hm_rr, ml_rr}, 7'b0100_10_0);
            cyc();
            cmp("b4_handover", {g_rr, hm_rr, ml_rr}, 7'b0001_10_0);
            cmp("b4_handover_fp", {g_fp, hm_fp, ml_fp}, 7'b0001_10_0);
        end

        // Locked sequence by master 1.
        drive(4'b0010, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1); cyc();
        cmp("lk_grant1", {g_rr, hm_rr, ml_rr}, 7'b0010_00_0);
        drive(4'b1111, 4'b0010, HTRANS_NONSEQ, HBURST_INCR, 1'b1); cyc();
        cmp("lk_enter", {g_rr, hm_rr, ml_rr}, 7'b0010_01_1);
        htrans = HTRANS_SEQ;
        for (int k = 0; k < 3; k++) begin
            cyc();
            cmp("lk_hold", {g_rr, hm_rr, ml_rr}, 7'b0010_01_1);
        end
        lock = 4'b0000; cyc();
        cmp("lk_tail", {g_rr, hm_rr, ml_rr}, 7'b0010_01_0);
        drive(4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1); cyc();
        cmp("lk_regrant", {g_rr, hm_rr, ml_rr}, 7'b0100_01_0);
        drive(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1); cyc();
        cmp("lk_after", {g_rr, hm_rr, ml_rr}, 7'b0001_10_0);

        // Asynchronous reset in the middle of an INCR8.
        drive(4'b1000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1); cyc();
        drive(4'b1001, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8, 1'b1); cyc();
        htrans = HTRANS_SEQ; cyc(); cyc();
        cmp("b8_mid", {g_rr, hm_rr, ml_rr}, 7'b1000_11_0);
        #2 HRESETn = 1'b0;
        model_reset();
        #1;
        cmp("arst_rr", {g_rr, hm_rr, ml_rr}, 7'b0001_00_0);
        cmp("arst_fp", {g_fp, hm_fp, ml_fp}, 7'b0001_00_0);
        cyc(); cyc();
        HRESETn = 1'b1;

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            busreq = 4'($urandom);
            if ($urandom_range(0, 9) == 0) lock = 4'($urandom) & 4'($urandom);
            htrans = ($urandom_range(0, 9) < 5) ? HTRANS_SEQ : 2'($urandom);
            hburst = 3'($urandom);
            hready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        @(posedge HCLK);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
